mem_access_unit: RTL and testbench

//  Memory-stage front end for the 4K-word data memory: accepts one load/store per handshake and sequences the memory cycles.

---
 rtl/mem_access_unit_if.sv | 40 ++++
 rtl/mem_access_unit.sv | 156 +++++++++++++++
 tb/tb_mem_access_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/response handshake and data-memory bus of the memory-stage front end.
interface mem_access_unit_if #(
  parameter int ADDR_W = 12
);
  // request side
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       req_pc;
  // data memory side
  logic [ADDR_W-1:0] dm_a;
  logic [31:0]       dm_wdata;
  logic [3:0]        dm_be;
  logic              dm_memread;
  logic              dm_memwrite;
  logic [31:0]       dm_pc;
  logic [31:0]       dm_rd;
  // response side
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_exc;
  logic [31:0]       rsp_pc;

  // the access unit itself
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_pc, rsp_ready, dm_rd,
    output req_ready, dm_a, dm_wdata, dm_be, dm_memread, dm_memwrite, dm_pc,
           rsp_valid, rsp_rdata, rsp_exc, rsp_pc
  );

  // pipeline stage plus data memory surrounding the unit
  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_pc, rsp_ready, dm_rd,
    input  req_ready, dm_a, dm_wdata, dm_be, dm_memread, dm_memwrite, dm_pc,
           rsp_valid, rsp_rdata, rsp_exc, rsp_pc
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage front end: one load/store in flight, sequencing read, write or
// read-modify-write cycles on a word-wide data memory that zero-fills disabled bytes.
module mem_access_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,   // asynchronous, active low
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RSP} state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_op;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_pc;
  logic [31:0]       r_data;    // load result, or old word for SH/SB
  logic [1:0]        r_exc;

  logic              w_accept;
  logic              w_req_load;
  logic              w_req_exc;
  logic              w_is_load;
  logic              w_mem_cycle;
  logic [31:0]       w_ext;
  logic [31:0]       w_merge;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;

  // Request classification and exception check on the unregistered request.
  always_comb begin
    logic w_word, w_halfop, w_mis, w_oor;
    w_word     = (bus.req_op == OP_LW) || (bus.req_op == OP_SW);
    w_halfop   = (bus.req_op == OP_LH) || (bus.req_op == OP_LHU) || (bus.req_op == OP_SH);
    w_req_load = (bus.req_op <= OP_LBU);
    w_mis      = (w_word && (bus.req_addr[1:0] != 2'b00)) || (w_halfop && bus.req_addr[0]);
    w_oor      = (bus.req_addr[31:ADDR_W+2] != '0);
    w_req_exc  = w_mis || w_oor;
  end

  assign w_accept    = bus.req_valid && (r_state == S_IDLE);
  assign w_is_load   = (r_op <= OP_LBU);
  assign w_mem_cycle = (r_state == S_RD) || (r_state == S_WR);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and strobes; strobes come straight from the state so reset kills them at once.
  always_comb begin
    w_state_next    = r_state;
    bus.req_ready   = 1'b0;
    bus.dm_memread  = 1'b0;
    bus.dm_memwrite = 1'b0;
    bus.dm_be       = 4'b0000;
    bus.rsp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_req_exc)               w_state_next = S_RSP;
          else if (bus.req_op == OP_SW) w_state_next = S_WR;
          else                         w_state_next = S_RD;
        end
      end
      S_RD: begin
        bus.dm_memread = 1'b1;
        w_state_next   = w_is_load ? S_RSP : S_WR;
      end
      S_WR: begin
        bus.dm_memwrite = 1'b1;
        bus.dm_be       = 4'b1111;
        w_state_next    = S_RSP;
      end
      S_RSP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Lane selection and load extension from the combinational read data.
  always_comb begin
    w_half = r_addr[1] ? bus.dm_rd[31:16] : bus.dm_rd[15:0];
    case (r_addr[1:0])
      2'd0:    w_byte = bus.dm_rd[7:0];
      2'd1:    w_byte = bus.dm_rd[15:8];
      2'd2:    w_byte = bus.dm_rd[23:16];
      default: w_byte = bus.dm_rd[31:24];
    endcase
    case (r_op)
      OP_LH:   w_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_ext = {16'h0, w_half};
      OP_LB:   w_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_ext = {24'h0, w_byte};
      default: w_ext = bus.dm_rd;
    endcase
  end

  // Store word: full word for SW, old word with one lane replaced for SH/SB.
  always_comb begin
    w_merge = r_data;
    case (r_op)
      OP_SW: w_merge = r_wdata;
      OP_SH: begin
        if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
        else           w_merge[15:0]  = r_wdata[15:0];
      end
      OP_SB: w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      default: w_merge = r_data;
    endcase
  end

  // Request capture at accept and read-data capture at the end of RD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
      r_data  <= '0;
      r_exc   <= '0;
    end else if (w_accept) begin
      r_op    <= bus.req_op;
      r_addr  <= bus.req_addr[ADDR_W+1:0];
      r_wdata <= bus.req_wdata;
      r_pc    <= bus.req_pc;
      r_data  <= '0;
      r_exc   <= w_req_exc ? (w_req_load ? 2'd1 : 2'd2) : 2'd0;
    end else if (r_state == S_RD) begin
      r_data  <= w_is_load ? w_ext : bus.dm_rd;
    end
  end

  assign bus.dm_a      = w_mem_cycle ? r_addr[ADDR_W+1:2] : '0;
  assign bus.dm_pc     = w_mem_cycle ? r_pc : '0;
  assign bus.dm_wdata  = (r_state == S_WR) ? w_merge : '0;
  assign bus.rsp_rdata = ((r_state == S_RSP) && w_is_load && (r_exc == 2'd0)) ? r_data : '0;
  assign bus.rsp_exc   = (r_state == S_RSP) ? r_exc : 2'd0;
  assign bus.rsp_pc    = (r_state == S_RSP) ? r_pc : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases followed by random loads/stores,
// checked against a byte-lane reference model over a shadow copy of memory.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  bit [31:0] mem    [4096];
  bit [31:0] shadow [4096];

  mem_access_unit_if #(.ADDR_W(12)) bus ();

  mem_access_unit #(.ADDR_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // data memory: combinational read, write sampled at posedge
  assign bus.dm_rd = mem[bus.dm_a];
  always @(posedge clk) if (bus.dm_memwrite) mem[bus.dm_a] <= bus.dm_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: byte-addressed semantics over the shadow memory.
  function automatic void model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rdata, output logic [1:0] exc,
                                output int lat, output int nrd, output int nwr);
    int size;
    bit is_load;
    logic [31:0] mask, v;
    int sh, widx;
    size    = (op == 0 || op == 5) ? 4 : (op == 1 || op == 2 || op == 6) ? 2 : 1;
    is_load = (op < 5);
    rdata = 0; exc = 0; lat = 0; nrd = 0; nwr = 0;
    if ((addr % size) != 0 || addr >= 32'h4000) begin
      exc = is_load ? 2'd1 : 2'd2;
      lat = 1;
      return;
    end
    widx = int'(addr >> 2);
    sh   = 8 * int'(addr % 4);
    mask = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    if (is_load) begin
      v = (shadow[widx] >> sh) & mask;
      if ((op == 1 || op == 3) && ((v & ((mask >> 1) + 1)) != 0)) v = v | ~mask;
      rdata = v;
      lat = 2;
      nrd = 1;
    end else begin
      shadow[widx] = (shadow[widx] & ~(mask << sh)) | ((wd & mask) << sh);
      lat = (size == 4) ? 2 : 3;
      nrd = (size == 4) ? 0 : 1;
      nwr = 1;
    end
  endfunction

  task automatic txn(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] pc, input int hold);
    logic [31:0] e_rdata, s_rdata, s_pc;
    logic [1:0]  e_exc, s_exc;
    int e_lat, e_nrd, e_nwr, lat, nrd, nwr, widx;
    bit got;
    widx = int'(addr[13:2]);
    model(op, addr, wd, e_rdata, e_exc, e_lat, e_nrd, e_nwr);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
    bus.req_wdata = wd; bus.req_pc = pc;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (bus.dm_memread) nrd++;
      if (bus.dm_memwrite) begin
        nwr++;
        chk("dm_be", {28'b0, bus.dm_be}, 32'hF);
        chk("dm_a", {20'b0, bus.dm_a}, widx);
        chk("dm_pc", bus.dm_pc, pc);
      end
      if (bus.rsp_valid) got = 1;
    end
    chk("rsp_seen", {31'b0, got}, 32'd1);
    chk("latency", lat, e_lat);
    chk("nread", nrd, e_nrd);
    chk("nwrite", nwr, e_nwr);
    chk("rdata", bus.rsp_rdata, e_rdata);
    chk("exc", {30'b0, bus.rsp_exc}, {30'b0, e_exc});
    chk("rsp_pc", bus.rsp_pc, pc);
    s_rdata = bus.rsp_rdata; s_exc = bus.rsp_exc; s_pc = bus.rsp_pc;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("hold_ready", {31'b0, bus.req_ready}, 32'd0);
      chk("hold_rdata", bus.rsp_rdata, s_rdata);
      chk("hold_exc", {30'b0, bus.rsp_exc}, {30'b0, s_exc});
      chk("hold_pc", bus.rsp_pc, s_pc);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    chk("mem_word", mem[widx], shadow[widx]);
    $display("txn op=%0d addr=%h wd=%h rdata=%h exc=%0d lat=%0d", op, addr, wd, s_rdata, s_exc, lat);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  op;
    bus.req_valid = 0; bus.req_op = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_pc = 0; bus.rsp_ready = 0;
    repeat (3) @(negedge clk);
    // reset state while reset held
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_memread", {31'b0, bus.dm_memread}, 32'd0);
    chk("rst_memwrite", {31'b0, bus.dm_memwrite}, 32'd0);
    chk("rst_be", {28'b0, bus.dm_be}, 32'd0);
    chk("rst_dm_a", {20'b0, bus.dm_a}, 32'd0);
    reset = 1'b1;

    // directed cases
    txn(3'd5, 32'h10, 32'hDEADBEEF, 32'h100, 0);   // SW
    txn(3'd7, 32'h11, 32'h00000055, 32'h104, 0);   // SB -> DEAD55EF
    txn(3'd0, 32'h10, 32'h0, 32'h108, 0);          // LW
    txn(3'd7, 32'h11, 32'h00000080, 32'h10C, 0);   // SB -> DEAD80EF
    txn(3'd3, 32'h11, 32'h0, 32'h110, 0);          // LB  -> FFFFFF80
    txn(3'd4, 32'h11, 32'h0, 32'h114, 0);          // LBU -> 00000080
    txn(3'd1, 32'h12, 32'h0, 32'h118, 0);          // LH  -> FFFFDEAD
    txn(3'd2, 32'h12, 32'h0, 32'h11C, 0);          // LHU -> 0000DEAD
    txn(3'd6, 32'h12, 32'h1234ABCD, 32'h120, 0);   // SH upper half
    txn(3'd0, 32'h13, 32'h0, 32'h124, 0);          // LW misaligned -> AdEL
    txn(3'd6, 32'h4001, 32'hFFFF, 32'h128, 0);     // SH misaligned + out of range -> AdES
    txn(3'd5, 32'h4000, 32'h1, 32'h12C, 0);        // first out-of-range word -> AdES
    txn(3'd0, 32'h3FFC, 32'h0, 32'h130, 0);        // last word in range
    txn(3'd0, 32'h10, 32'h0, 32'h134, 5);          // held response
    txn(3'd4, 32'h13, 32'h0, 32'h138, 0);          // accepted right after release

    // reset asserted while an SB sits in WR
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_op = 3'd7; bus.req_addr = 32'h11;
    bus.req_wdata = 32'h000000AA; bus.req_pc = 32'h200;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 chk("wr_strobe_before_rst", {31'b0, bus.dm_memwrite}, 32'd1);
    #2 reset = 1'b0;
    #1 chk("wr_strobe_after_rst", {31'b0, bus.dm_memwrite}, 32'd0);
    chk("ready_in_rst", {31'b0, bus.req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("rst_word_kept", mem[4], shadow[4]);
    chk("rst_idle_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_idle_valid", {31'b0, bus.rsp_valid}, 32'd0);
    $display("txn reset-during-WR word4=%h", mem[4]);

    // random mix, mostly within a small window so loads see earlier stores
    for (int n = 0; n < 200; n++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'h3FF0 + 32'($urandom_range(0, 31));
        default: a = 32'($urandom_range(0, 63));
      endcase
      txn(op, a, $urandom, $urandom, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
